// File: rtl/dotprod_acc_stream.sv
// Streaming signed dot-product engine: input register, registered lane
// multipliers, registered adder tree, then a wide accumulator that emits one
// (optionally saturated) result per in_last-tagged vector. A single global
// advance signal stalls the whole pipeline when the output is blocked.
module dotprod_acc_stream #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LANES    = 8,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned OUT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] vec_a [LANES-1:0],
  input  logic signed [DATA_W-1:0] vec_b [LANES-1:0],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int unsigned NUM_STAGES = $clog2(LANES);
  localparam int unsigned P2         = 1 << NUM_STAGES;
  // Heap-ordered tree: node 0 is the root, leaves P2-1 .. 2*P2-2 hold products.
  localparam int unsigned NODES      = 2 * P2 - 1;
  // Every node is kept at the root width; the value range per level still
  // grows by one bit, so this is numerically identical to per-level widening.
  localparam int unsigned TW         = 2 * DATA_W + NUM_STAGES;
  localparam int unsigned PW         = 2 * DATA_W;
  // Tag pipeline: [0] input register, [1] products, [1+k] tree level k.
  localparam int unsigned DEPTH      = NUM_STAGES + 2;

  localparam logic [ACC_W-1:0]        SAT_MAX_U = {1'b0, {(ACC_W-1){1'b1}}} >> (ACC_W - OUT_W);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = SAT_MAX_U;
  localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

  logic                     adv;

  logic signed [DATA_W-1:0] a_q [LANES-1:0];
  logic signed [DATA_W-1:0] a_d [LANES-1:0];
  logic signed [DATA_W-1:0] b_q [LANES-1:0];
  logic signed [DATA_W-1:0] b_d [LANES-1:0];

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0]         last_q, last_d;

  logic signed [TW-1:0]     node_q [NODES];
  logic signed [TW-1:0]     node_d [NODES];
  logic signed [PW-1:0]     prod;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  // Global advance: the pipeline moves unless a finished result is blocked.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = adv && rst_n;
  end

  // Input register and valid/last tag shift chain.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (adv) begin
      vld_d  = {vld_q[DEPTH-2:0], in_valid};
      last_d = {last_q[DEPTH-2:0], in_last};
      if (in_valid) begin
        a_d = vec_a;
        b_d = vec_b;
      end
    end
  end

  // Multiplier leaves and adder tree levels; padding lanes contribute zero.
  always_comb begin
    node_d = node_q;
    prod   = '0;
    if (adv) begin
      for (int unsigned i = 0; i < P2 - 1; i++) begin
        node_d[i] = node_q[2*i+1] + node_q[2*i+2];
      end
      for (int unsigned l = 0; l < P2; l++) begin
        if (l < LANES) begin
          prod = PW'(a_q[l]) * PW'(b_q[l]);
          node_d[P2-1+l] = TW'(prod);
        end else begin
          node_d[P2-1+l] = '0;
        end
      end
    end
  end

  // Accumulate tree results; a last-tagged result is emitted and clears the sum.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sum         = acc_q + ACC_W'(node_q[0]);
    if (adv) begin
      out_valid_d = 1'b0;
      if (vld_q[DEPTH-1]) begin
        if (last_q[DEPTH-1]) begin
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_sat_d   = 1'b0;
          out_data_d  = sum[OUT_W-1:0];
          if (SATURATE && (sum > SAT_MAX)) begin
            out_data_d = SAT_MAX[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else if (SATURATE && (sum < SAT_MIN)) begin
            out_data_d = SAT_MIN[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  // State registers; reset discards any partially accumulated vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        a_q[l] <= '0;
        b_q[l] <= '0;
      end
      for (int unsigned i = 0; i < NODES; i++) begin
        node_q[i] <= '0;
      end
      vld_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      node_q      <= node_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dotprod_acc_stream.sv
// Bench for dotprod_acc_stream: an 8-lane saturating 16-bit-output instance and
// a 5-lane truncating 32-bit-output instance, checked against a per-vector
// arithmetic model of the dot product.
module tb_dotprod_acc_stream;

  typedef logic signed [15:0] vec8_t [7:0];
  typedef logic signed [15:0] vec5_t [4:0];
  typedef struct { logic [63:0] d; bit s; } res_t;

  logic clk = 1'b0;
  logic rst_n;

  logic              in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_sat8;
  logic signed [15:0] a8 [7:0];
  logic signed [15:0] b8 [7:0];
  logic [15:0]       out_data8;

  logic              in_valid5, in_ready5, in_last5, out_valid5, out_ready5, out_sat5;
  logic signed [15:0] a5 [4:0];
  logic signed [15:0] b5 [4:0];
  logic [31:0]       out_data5;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dotprod_acc_stream #(.DATA_W(16), .LANES(8), .ACC_W(40), .OUT_W(16), .SATURATE(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_last(in_last8),
    .vec_a(a8), .vec_b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_sat(out_sat8));

  dotprod_acc_stream #(.DATA_W(16), .LANES(5), .ACC_W(40), .OUT_W(32), .SATURATE(1'b0)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .in_last(in_last5),
    .vec_a(a5), .vec_b(b5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_data(out_data5), .out_sat(out_sat5));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact dot product, wrapped to accw bits, then clamped or truncated to outw bits.
  function automatic logic [63:0] model_res(input longint sum, input int accw, input int outw,
                                            input bit sat_en, output bit sat);
    longint r, mx, mn;
    r   = (sum <<< (64 - accw)) >>> (64 - accw);
    mx  = (longint'(1) <<< (outw - 1)) - 1;
    mn  = -mx - 1;
    sat = 1'b0;
    if (sat_en && r > mx) begin r = mx; sat = 1'b1; end
    else if (sat_en && r < mn) begin r = mn; sat = 1'b1; end
    return 64'(r) & ((64'd1 << outw) - 64'd1);
  endfunction

  function automatic logic signed [15:0] rnd16(input int mode);
    case (mode)
      0:       return 16'($urandom_range(0, 100) - 50);
      1:       return 16'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
    endcase
  endfunction

  // Reference model and output scoreboard for both instances.
  longint acc8 = 0, acc5 = 0;
  res_t   q8[$], q5[$];
  logic [15:0] hold_d8;
  logic [31:0] hold_d5;
  bit     hold_s8, hold_s5, held8 = 0, held5 = 0;

  always @(negedge clk) begin
    res_t r;
    bit   s;
    if (!rst_n) begin
      acc8 = 0; acc5 = 0; q8.delete(); q5.delete(); held8 = 0; held5 = 0;
    end else begin
      if (held8) begin
        check("stall8_valid", out_valid8, 1);
        check("stall8_data", out_data8, hold_d8);
        check("stall8_sat", out_sat8, hold_s8);
      end
      held8 = out_valid8 && !out_ready8; hold_d8 = out_data8; hold_s8 = out_sat8;
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) check("spurious8", out_valid8, 0);
        else begin
          r = q8.pop_front();
          check("res8_data", out_data8, r.d);
          check("res8_sat", out_sat8, r.s);
        end
      end
      if (in_valid8 && in_ready8) begin
        for (int i = 0; i < 8; i++) acc8 += longint'(a8[i]) * longint'(b8[i]);
        if (in_last8) begin
          r.d = model_res(acc8, 40, 16, 1'b1, s); r.s = s; q8.push_back(r); acc8 = 0;
        end
      end

      if (held5) begin
        check("stall5_valid", out_valid5, 1);
        check("stall5_data", out_data5, hold_d5);
        check("stall5_sat", out_sat5, hold_s5);
      end
      held5 = out_valid5 && !out_ready5; hold_d5 = out_data5; hold_s5 = out_sat5;
      if (out_valid5 && out_ready5) begin
        if (q5.size() == 0) check("spurious5", out_valid5, 0);
        else begin
          r = q5.pop_front();
          check("res5_data", out_data5, r.d);
          check("res5_sat", out_sat5, r.s);
        end
      end
      if (in_valid5 && in_ready5) begin
        for (int i = 0; i < 5; i++) acc5 += longint'(a5[i]) * longint'(b5[i]);
        if (in_last5) begin
          r.d = model_res(acc5, 40, 32, 1'b0, s); r.s = s; q5.push_back(r); acc5 = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send8(input vec8_t a, input vec8_t b, input bit last);
    int n;
    a8 = a; b8 = b; in_last8 = last; in_valid8 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready8) check("send8_timeout", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic send5(input vec5_t a, input vec5_t b, input bit last);
    int n;
    a5 = a; b5 = b; in_last5 = last; in_valid5 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready5 && n < 200) begin @(negedge clk); n++; end
    if (!in_ready5) check("send5_timeout", in_ready5, 1);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  task automatic wait_out8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_out5(output int lat);
    lat = 0;
    while (!out_valid5 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit done8 = 0, done5 = 0;

  initial begin
    vec8_t va, vb;
    vec5_t wa, wb;
    int    lat;
    bit    seen, stall_seen;

    rst_n = 1'b0;
    in_valid8 = 0; in_last8 = 0; out_ready8 = 1;
    in_valid5 = 0; in_last5 = 0; out_ready5 = 1;
    for (int i = 0; i < 8; i++) begin a8[i] = '0; b8[i] = '0; end
    for (int i = 0; i < 5; i++) begin a5[i] = '0; b5[i] = '0; end
    #2;
    check("rst_out_valid8", out_valid8, 0);
    check("rst_out_data8", out_data8, 0);
    check("rst_in_ready8", in_ready8, 0);
    check("rst_out_valid5", out_valid5, 0);
    check("rst_in_ready5", in_ready5, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, a=1..8, b=1
    for (int i = 0; i < 8; i++) begin va[i] = 16'(i + 1); vb[i] = 16'sd1; end
    send8(va, vb, 1'b1);
    wait_out8(lat);
    check("t1_latency", lat, 5);
    check("t1_data", out_data8, 36);
    check("t1_sat", out_sat8, 0);
    @(posedge clk); #1;

    // 2: three beats a=2, b=3; nothing emitted before the last beat
    for (int i = 0; i < 8; i++) begin va[i] = 16'sd2; vb[i] = 16'sd3; end
    send8(va, vb, 1'b0);
    send8(va, vb, 1'b0);
    seen = 0;
    repeat (8) begin if (out_valid8) seen = 1; @(posedge clk); #1; end
    check("t2_no_early_out", seen, 0);
    send8(va, vb, 1'b1);
    wait_out8(lat);
    check("t2_data", out_data8, 144);
    @(posedge clk); #1;

    // 3: stall the output 6 cycles while four single-beat vectors stream in
    stall_seen = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          for (int i = 0; i < 8; i++) begin va[i] = 16'(k * 10 + i + 1); vb[i] = 16'sd1; end
          send8(va, vb, 1'b1);
          repeat (2) @(posedge clk);
          #1;
        end
      end
      begin
        int n;
        n = 0;
        while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
        out_ready8 = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (!in_ready8) stall_seen = 1;
          @(posedge clk); #1;
        end
        out_ready8 = 1'b1;
      end
    join
    check("t3_in_ready_dropped", stall_seen, 1);
    repeat (20) @(posedge clk);
    #1;
    check("t3_drained", q8.size(), 0);

    // 4: saturation at both ends of the 16-bit output range
    for (int i = 0; i < 8; i++) begin va[i] = 16'sh7fff; vb[i] = 16'sh7fff; end
    send8(va, vb, 1'b1);
    wait_out8(lat);
    check("t4_max_data", out_data8, 64'h7fff);
    check("t4_max_sat", out_sat8, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin va[i] = 16'sh7fff; vb[i] = 16'sh8000; end
    send8(va, vb, 1'b1);
    wait_out8(lat);
    check("t4_min_data", out_data8, 64'h8000);
    check("t4_min_sat", out_sat8, 1);
    repeat (3) @(posedge clk);
    #1;

    // 5: reset mid-vector, then a fresh single-beat vector
    for (int i = 0; i < 8; i++) begin va[i] = 16'sd5; vb[i] = 16'sd7; end
    send8(va, vb, 1'b0);
    send8(va, vb, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid8, 0);
    check("t5_rst_out_data", out_data8, 0);
    check("t5_rst_out_sat", out_sat8, 0);
    check("t5_rst_in_ready", in_ready8, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin va[i] = 16'sd1; vb[i] = 16'sd1; end
    send8(va, vb, 1'b1);
    wait_out8(lat);
    check("t5_data", out_data8, 8);
    @(posedge clk); #1;

    // 6: five lanes padded to an 8-leaf tree
    for (int i = 0; i < 5; i++) begin wa[i] = 16'(i + 1); wb[i] = 16'(5 - i); end
    send5(wa, wb, 1'b1);
    wait_out5(lat);
    check("t6_latency", lat, 5);
    check("t6_data", out_data5, 35);
    check("t6_sat", out_sat5, 0);
    @(posedge clk); #1;

    // Random multi-beat vectors with random gaps and backpressure on both instances
    fork
      begin
        vec8_t ra, rb;
        int nb, mode;
        for (int v = 0; v < 60; v++) begin
          nb = $urandom_range(1, 4);
          mode = $urandom_range(0, 2);
          for (int bt = 0; bt < nb; bt++) begin
            for (int i = 0; i < 8; i++) begin ra[i] = rnd16(mode); rb[i] = rnd16(mode); end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send8(ra, rb, bt == nb - 1);
          end
        end
        done8 = 1;
      end
      begin
        while (!done8) begin @(posedge clk); #1; out_ready8 = ($urandom_range(0, 3) != 0); end
        out_ready8 = 1'b1;
      end
      begin
        vec5_t ra, rb;
        int nb;
        for (int v = 0; v < 60; v++) begin
          nb = $urandom_range(1, 4);
          for (int bt = 0; bt < nb; bt++) begin
            for (int i = 0; i < 5; i++) begin ra[i] = rnd16(1); rb[i] = rnd16(1); end
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send5(ra, rb, bt == nb - 1);
          end
        end
        done5 = 1;
      end
      begin
        while (!done5) begin @(posedge clk); #1; out_ready5 = ($urandom_range(0, 2) != 0); end
        out_ready5 = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("rand8_drained", q8.size(), 0);
    check("rand5_drained", q5.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
